cdb_writeback_arbiter: RTL
==========================

# cdb_writeback_arbiter

Parametrised common-data-bus (CDB) write-back stage for the Tomasulo core. It collects completed results from `NUM_FU` execution units, arbitrates them onto `NUM_CDB` broadcast slots per cycle, and drives the registered broadcast that the ROB and all reservation stations snoop. The broadcast sets the ROB value, marks the entry ready-to-retire, wakes up waiting operands and frees the producing RS entry. The stage replaces the fixed three-producer, one-broadcast-per-producer write-back with back-pressure, configurable arbitration and flush support.

## Interface
- `NUM_FU`, 3, number of producing execution units
- `NUM_CDB`, 1, broadcast slots per cycle (1..`NUM_FU`)
- `XLEN`, 32, result value width
- `ROB_DEPTH`, 16, ROB entries; `TAG_W` = `$clog2(ROB_DEPTH)`
- `RS_DEPTH`, 4, entries per reservation station; `RSI_W` = `$clog2(RS_DEPTH)`
- `ARB_MODE`, 0, 0 = round-robin, 1 = fixed priority (lowest FU index wins)

Ports:
- `clk`  in  1  single clock; all state on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous pipeline flush (mispredict)
- `fu_valid`  in  `NUM_FU`  FU presents a result
- `fu_ready`  out  `NUM_FU`  stage accepts the result this cycle
- `fu_tag`  in  `NUM_FU*TAG_W`  destination ROB index per FU
- `fu_value`  in  `NUM_FU*XLEN`  result value per FU
- `fu_rs_idx`  in  `NUM_FU*RSI_W`  RS entry to free per FU
- `cdb_valid`  out  `NUM_CDB`  broadcast slot active
- `cdb_tag`  out  `NUM_CDB*TAG_W`  ROB tag broadcast
- `cdb_value`  out  `NUM_CDB*XLEN`  value broadcast
- `cdb_fu_id`  out  `NUM_CDB*$clog2(NUM_FU)`  producing FU, so the RS owner can free its entry
- `cdb_rs_idx`  out  `NUM_CDB*RSI_W`  RS entry to free
- `bcast_count`  out  32  saturating count of broadcasts since reset

## Operation
- Each FU has one holding register (`hold_v`, tag, value, rs_idx). Accept when `fu_valid & fu_ready`.
- `fu_ready[i] = !flush & (!hold_v[i] | grant[i])`. This is combinational, so a granted FU can hand over a new result in the same cycle.
- Arbiter: among `hold_v`, grant up to `NUM_CDB` FUs per cycle.
  - Round-robin: scan starts at `rr_ptr`. Slot 0 gets the first hit, slot 1 the next, and so on.
  - After any grant, `rr_ptr` moves to one past the highest-order (last scanned) granted FU, modulo `NUM_FU`. With no grant, `rr_ptr` holds.
  - Fixed priority: scan starts at 0 and `rr_ptr` is unused.
- Granted holds load into the `cdb_*` output registers. Unused slots get `cdb_valid=0`, and their other fields hold their previous value.
- A grant clears `hold_v` unless the same FU is accepted in the same cycle, in which case the hold reloads with the new result.
- `bcast_count` adds popcount(`cdb_valid` next) each cycle and saturates at 0xFFFF_FFFF.
- `flush`: at the next edge, clear all `hold_v` and `cdb_valid` and reset `rr_ptr` to 0. Nothing is granted or accepted in the flush cycle. `bcast_count` is not affected.
- No tag-uniqueness check. Duplicate tags are broadcast as presented.

## Timing
- Reset values: `cdb_valid=0`, `cdb_tag/value/fu_id/rs_idx=0`, `bcast_count=0`, `hold_v=0`, `rr_ptr=0`. `fu_ready` is all-ones once `rst_n` is high and `flush=0`.
- Latency: a result accepted at edge k is broadcast at edge k+1 at the earliest, so `cdb_valid` is high for the cycle k+1→k+2. Each broadcast lasts exactly one cycle.
- Throughput: up to `NUM_CDB` results per cycle. Per FU, one result per cycle while granted every cycle.
- Round-robin bound: a held result waits at most `ceil(NUM_FU/NUM_CDB)-1` cycles.
- If `NUM_CDB >= NUM_FU`, every hold is granted every cycle and `fu_ready` is constant 1 outside flush.
- Reset asserted mid-operation: all state clears immediately (asynchronously), and in-flight holds are lost.

## Structure
- The shared `tomasulo_pkg` defines:
  - `TAG_W`/`RSI_W` helper functions
  - `cdb_slot_t` (valid, tag, value, fu_id, rs_idx)
  - the `ARB_RR`/`ARB_FIXED` constants
- Sub-module `multi_grant_arbiter` (`N`, `G`, `MODE`) holds the grant logic: request vector + `rr_ptr` → `G` one-hot grants + next pointer. It is purely combinational; the pointer register stays in the parent.

## Test plan
- Reset, then FU1 presents tag 5, value 0xDEADBEEF, rs_idx 2 → one cycle later `cdb_valid[0]=1`, tag 5, value 0xDEADBEEF, fu_id 1, rs_idx 2, `bcast_count=1`.
- `NUM_FU=3`, `NUM_CDB=1`, RR, all three FUs present tags 1/2/3 at once → broadcasts in order FU0, FU1, FU2 on consecutive cycles; `fu_ready` of waiting FUs stays low until each is granted.
- `NUM_CDB=2`, FU0–FU2 valid every cycle → two broadcasts per cycle, and over 6 cycles each FU is granted exactly 4 times.
- `ARB_MODE=1`, FU0 continuously valid, FU2 valid → FU2 never granted while FU0 streams, and granted the cycle after FU0 drops.
- Holds full, assert `flush` for 1 cycle → next cycle `cdb_valid=0`, all `fu_ready=1`, `rr_ptr=0`, and no stale tag is ever broadcast.
- Drop `rst_n` asynchronously mid-cycle with holds full → outputs zero before the next edge, and `bcast_count=0`.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: width helpers, arbitration modes and the
// CDB broadcast slot record.
package tomasulo_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Widths of the default core configuration, used by cdb_slot_t.
  localparam int CORE_XLEN   = 32;
  localparam int CORE_TAG_W  = 4;
  localparam int CORE_RSI_W  = 2;
  localparam int CORE_FID_W  = 2;

  // $clog2 that never returns zero, so a one-entry structure still gets a bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_w(input int rob_depth);
    return clog2_min1(rob_depth);
  endfunction

  function automatic int rsi_w(input int rs_depth);
    return clog2_min1(rs_depth);
  endfunction

  function automatic int fu_id_w(input int num_fu);
    return clog2_min1(num_fu);
  endfunction

  // One broadcast slot as snooped by the ROB and reservation stations.
  typedef struct packed {
    logic                  valid;
    logic [CORE_TAG_W-1:0] tag;
    logic [CORE_XLEN-1:0]  value;
    logic [CORE_FID_W-1:0] fu_id;
    logic [CORE_RSI_W-1:0] rs_idx;
  } cdb_slot_t;

endpackage

// File: rtl/multi_grant_arbiter.sv
// Combinational multi-grant arbiter: picks up to G requesters per cycle,
// scanning from ptr (round-robin) or from 0 (fixed priority), and reports the
// pointer value that follows the last granted requester.
module multi_grant_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N    = 3,
  parameter int G    = 1,
  parameter int MODE = ARB_RR,
  parameter int IW   = 2
) (
  input  logic [N-1:0]         req,
  input  logic [IW-1:0]        ptr,
  output logic [G-1:0]         grant_valid,
  output logic [G-1:0][N-1:0]  grant_oh,
  output logic [G-1:0][IW-1:0] grant_idx,
  output logic [N-1:0]         grant_any,
  output logic [IW-1:0]        next_ptr
);

  int   start;
  int   pos;
  int   slot;
  int   last;
  logic hit;

  // Scan requesters in priority order, filling slots 0..G-1 with the first hits.
  always_comb begin
    grant_valid = '0;
    grant_oh    = '0;
    grant_idx   = '0;
    grant_any   = '0;
    next_ptr    = ptr;
    start       = (MODE == ARB_RR) ? int'(ptr) : 0;
    pos         = 0;
    slot        = 0;
    last        = -1;
    hit         = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = start + k;
      if (pos >= N) pos = pos - N;
      hit = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (j == pos && req[j]) hit = 1'b1;
      end
      if (hit && slot < G) begin
        for (int s = 0; s < G; s++) begin
          if (s == slot) begin
            grant_valid[s] = 1'b1;
            grant_idx[s]   = IW'(pos);
            for (int j = 0; j < N; j++) begin
              if (j == pos) grant_oh[s][j] = 1'b1;
            end
          end
        end
        for (int j = 0; j < N; j++) begin
          if (j == pos) grant_any[j] = 1'b1;
        end
        last = pos;
        slot = slot + 1;
      end
    end
    if (MODE != ARB_RR) next_ptr = '0;
    else if (last >= 0) next_ptr = (last + 1 >= N) ? '0 : IW'(last + 1);
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// CDB write-back stage: one holding register per execution unit, arbitration
// onto NUM_CDB broadcast slots, registered broadcast and a saturating count.
//
// Handshake: an FU result transfers on a rising edge where fu_valid[i] and
// fu_ready[i] are both high. fu_ready[i] is combinational: high when not
// flushing and the FU's hold is empty or being granted this cycle, so a
// granted FU may hand over its next result in the same cycle.
module cdb_writeback_arbiter
  import tomasulo_pkg::*;
#(
  parameter  int NUM_FU    = 3,
  parameter  int NUM_CDB   = 1,
  parameter  int XLEN      = 32,
  parameter  int ROB_DEPTH = 16,
  parameter  int RS_DEPTH  = 4,
  parameter  int ARB_MODE  = ARB_RR,
  localparam int TAG_W     = tag_w(ROB_DEPTH),
  localparam int RSI_W     = rsi_w(RS_DEPTH),
  localparam int FID_W     = fu_id_w(NUM_FU)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*XLEN-1:0]   fu_value,
  input  logic [NUM_FU*RSI_W-1:0]  fu_rs_idx,
  output logic [NUM_CDB-1:0]       cdb_valid,
  output logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  output logic [NUM_CDB*XLEN-1:0]  cdb_value,
  output logic [NUM_CDB*FID_W-1:0] cdb_fu_id,
  output logic [NUM_CDB*RSI_W-1:0] cdb_rs_idx,
  output logic [31:0]              bcast_count
);

  logic [NUM_FU-1:0]                  hold_v;
  logic [NUM_FU-1:0][TAG_W-1:0]       hold_tag;
  logic [NUM_FU-1:0][XLEN-1:0]        hold_value;
  logic [NUM_FU-1:0][RSI_W-1:0]       hold_rs;
  logic [NUM_FU-1:0][TAG_W-1:0]       fu_tag_a;
  logic [NUM_FU-1:0][XLEN-1:0]        fu_value_a;
  logic [NUM_FU-1:0][RSI_W-1:0]       fu_rs_a;
  logic [FID_W-1:0]                   rr_ptr;
  logic [FID_W-1:0]                   rr_ptr_next;
  logic [NUM_FU-1:0]                  arb_req;
  logic [NUM_FU-1:0]                  grant_any;
  logic [NUM_FU-1:0]                  accept;
  logic [NUM_CDB-1:0]                 grant_valid;
  logic [NUM_CDB-1:0][NUM_FU-1:0]     grant_oh;
  logic [NUM_CDB-1:0][FID_W-1:0]      grant_idx;
  logic [NUM_CDB-1:0][TAG_W-1:0]      slot_tag;
  logic [NUM_CDB-1:0][XLEN-1:0]       slot_value;
  logic [NUM_CDB-1:0][RSI_W-1:0]      slot_rs;
  logic [31:0]                        grant_cnt;

  assign fu_tag_a   = fu_tag;
  assign fu_value_a = fu_value;
  assign fu_rs_a    = fu_rs_idx;

  // A flush cycle neither grants nor accepts anything.
  assign arb_req  = flush ? '0 : hold_v;
  assign fu_ready = {NUM_FU{~flush}} & (~hold_v | grant_any);
  assign accept   = fu_valid & fu_ready;

  multi_grant_arbiter #(
    .N    (NUM_FU),
    .G    (NUM_CDB),
    .MODE (ARB_MODE),
    .IW   (FID_W)
  ) u_arb (
    .req         (arb_req),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx),
    .grant_any   (grant_any),
    .next_ptr    (rr_ptr_next)
  );

  // Route each granted hold onto its slot and count this cycle's broadcasts.
  always_comb begin
    slot_tag   = '0;
    slot_value = '0;
    slot_rs    = '0;
    grant_cnt  = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      grant_cnt = grant_cnt + 32'(grant_valid[s]);
      for (int j = 0; j < NUM_FU; j++) begin
        if (grant_oh[s][j]) begin
          slot_tag[s]   = slot_tag[s]   | hold_tag[j];
          slot_value[s] = slot_value[s] | hold_value[j];
          slot_rs[s]    = slot_rs[s]    | hold_rs[j];
        end
      end
    end
  end

  // Holding registers and round-robin pointer; an accept overrides the grant clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v     <= '0;
      hold_tag   <= '0;
      hold_value <= '0;
      hold_rs    <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      hold_v <= '0;
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_next;
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          hold_v[i]     <= 1'b1;
          hold_tag[i]   <= fu_tag_a[i];
          hold_value[i] <= fu_value_a[i];
          hold_rs[i]    <= fu_rs_a[i];
        end else if (grant_any[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // Registered broadcast; idle slots keep their last payload with valid low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid   <= '0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      cdb_fu_id   <= '0;
      cdb_rs_idx  <= '0;
      bcast_count <= '0;
    end else begin
      for (int s = 0; s < NUM_CDB; s++) begin
        cdb_valid[s] <= grant_valid[s];
        if (grant_valid[s]) begin
          cdb_tag[s*TAG_W +: TAG_W]    <= slot_tag[s];
          cdb_value[s*XLEN +: XLEN]    <= slot_value[s];
          cdb_fu_id[s*FID_W +: FID_W]  <= grant_idx[s];
          cdb_rs_idx[s*RSI_W +: RSI_W] <= slot_rs[s];
        end
      end
      if (grant_cnt > (32'hFFFF_FFFF - bcast_count)) bcast_count <= 32'hFFFF_FFFF;
      else bcast_count <= bcast_count + grant_cnt;
    end
  end

endmodule
